// File: rtl/spd_pkg.sv
// Shared types, limits and arithmetic helpers for the speed shaper.
package spd_pkg;

  typedef enum logic [1:0] {OFF, RUN, STOP, LOCK} spd_state_t;

  localparam logic signed [11:0] SPD_MAX = 12'sd2047;
  localparam logic signed [11:0] SPD_MIN = -12'sd2047;

  localparam logic [10:0] MIN_DUTY_DEF     = 11'd160;
  localparam logic [10:0] SLEW_DEF         = 11'd32;
  localparam logic [10:0] TOO_FAST_THR_DEF = 11'd1792;

  // Deadzone offset away from zero, then clamp symmetric so -2048 never appears.
  function automatic logic signed [11:0] shape(input logic signed [12:0] raw,
                                               input logic [10:0] dz);
    logic signed [13:0] adj;
    adj = {raw[12], raw};
    if (raw > 0)      adj = adj + $signed({3'b000, dz});
    else if (raw < 0) adj = adj - $signed({3'b000, dz});
    if (adj > 14'sd2047)       return SPD_MAX;
    else if (adj < -14'sd2047) return SPD_MIN;
    else                       return 12'(adj);
  endfunction

  function automatic logic signed [11:0] slew_next(input logic signed [11:0] cur,
                                                   input logic signed [11:0] tgt,
                                                   input logic [10:0] slew);
    logic signed [12:0] delta;
    logic signed [12:0] lim;
    delta = {tgt[11], tgt} - {cur[11], cur};
    lim   = $signed({2'b00, slew});
    if (delta > lim)       return cur + $signed({1'b0, slew});
    else if (delta < -lim) return cur - $signed({1'b0, slew});
    else                   return tgt;
  endfunction

  function automatic logic [10:0] mag(input logic signed [11:0] x);
    return x[11] ? 11'(-x) : x[10:0];
  endfunction

endpackage

// File: rtl/spd_shaper_slew_lim.sv
// Per-side slew limiter: moves current toward target by at most SLEW per step.
module slew_lim
  import spd_pkg::*;
#(
  parameter logic [10:0] SLEW = SLEW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic signed [11:0] target,
  output logic signed [11:0] current
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          current <= '0;
    else if (step_en) current <= slew_next(current, target, SLEW);
  end

endmodule

// File: rtl/spd_shaper.sv
// Mixes PID and steer into left/right speeds with deadzone, saturation, slew limiting and power/fault sequencing.
// Deadzone compensation is built in only when SPD_DEADZONE_COMP_EN is defined.
module spd_shaper
  import spd_pkg::*;
#(
  parameter logic [10:0] MIN_DUTY     = MIN_DUTY_DEF,
  parameter logic [10:0] SLEW         = SLEW_DEF,
  parameter logic [10:0] TOO_FAST_THR = TOO_FAST_THR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vld,
  input  logic signed [11:0] PID_cntrl,
  input  logic signed [11:0] steer,
  input  logic               pwr_up,
  input  logic               OVR_I_shtdwn,
  output logic signed [11:0] lft_spd,
  output logic signed [11:0] rght_spd,
  output logic               spd_vld,
  output logic               too_fast,
  output logic               locked
);

`ifdef SPD_DEADZONE_COMP_EN
  localparam logic [10:0] DZ = MIN_DUTY;
`else
  localparam logic [10:0] DZ = MIN_DUTY & 11'd0;
`endif

  logic signed [12:0] lft_raw, rght_raw;
  logic signed [11:0] lft_s1, rght_s1, lft_tgt, rght_tgt, lft_nxt, rght_nxt;
  logic               vld_d, shut_seen;
  spd_state_t         state;

  assign lft_raw  = {PID_cntrl[11], PID_cntrl} + {steer[11], steer};
  assign rght_raw = {PID_cntrl[11], PID_cntrl} - {steer[11], steer};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_d   <= 1'b0;
      lft_s1  <= '0;
      rght_s1 <= '0;
    end else begin
      vld_d <= vld;
      if (vld) begin
        lft_s1  <= shape(lft_raw, DZ);
        rght_s1 <= shape(rght_raw, DZ);
      end
    end
  end

  // Anything other than RUN drives the limiters toward zero.
  assign lft_tgt  = (state == RUN) ? lft_s1 : '0;
  assign rght_tgt = (state == RUN) ? rght_s1 : '0;

  slew_lim #(.SLEW(SLEW)) u_lft (
    .clk(clk), .rst(rst), .step_en(vld_d), .target(lft_tgt), .current(lft_spd)
  );

  slew_lim #(.SLEW(SLEW)) u_rght (
    .clk(clk), .rst(rst), .step_en(vld_d), .target(rght_tgt), .current(rght_spd)
  );

  // too_fast is judged on the values the limiters are about to load, so it lines up with them.
  assign lft_nxt  = slew_next(lft_spd, lft_tgt, SLEW);
  assign rght_nxt = slew_next(rght_spd, rght_tgt, SLEW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spd_vld  <= 1'b0;
      too_fast <= 1'b0;
    end else begin
      spd_vld <= vld_d;
      if (vld_d)
        too_fast <= (mag(lft_nxt) > TOO_FAST_THR) || (mag(rght_nxt) > TOO_FAST_THR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= OFF;
      shut_seen <= 1'b0;
      locked    <= 1'b0;
    end else begin
      case (state)
        OFF:  if (pwr_up && !OVR_I_shtdwn) state <= RUN;
        RUN:  if (!pwr_up || OVR_I_shtdwn) begin
                state     <= STOP;
                shut_seen <= OVR_I_shtdwn;
              end
        STOP: begin
                if (OVR_I_shtdwn) shut_seen <= 1'b1;
                if (lft_spd == 12'sd0 && rght_spd == 12'sd0) begin
                  state  <= (shut_seen || OVR_I_shtdwn) ? LOCK : OFF;
                  locked <= shut_seen || OVR_I_shtdwn;
                end
              end
        LOCK: if (!pwr_up) begin
                state     <= OFF;
                shut_seen <= 1'b0;
                locked    <= 1'b0;
              end
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_spd_shaper.sv
// Self-checking bench for spd_shaper: directed sequences, a target table and random traffic against a reference model.
module tb_spd_shaper;

`ifdef SPD_DEADZONE_COMP_EN
  localparam int DZ = 160;
`else
  localparam int DZ = 0;
`endif
  localparam int FINAL   = 400 + DZ;
  localparam int FIN_UPD = (FINAL + 31) / 32;
  localparam int M_OFF = 0, M_RUN = 1, M_STOP = 2, M_LOCK = 3;

  logic               clk, rst, vld, pwr_up, ovr;
  logic signed [11:0] pid, steer;
  logic signed [11:0] lft_spd, rght_spd;
  logic               spd_vld, too_fast, locked;

  spd_shaper dut (
    .clk(clk), .rst(rst), .vld(vld), .PID_cntrl(pid), .steer(steer),
    .pwr_up(pwr_up), .OVR_I_shtdwn(ovr), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .spd_vld(spd_vld), .too_fast(too_fast), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;

  // reference model state
  int m_st, m_shut, m_lk, m_s1l, m_s1r, m_vd, m_l, m_r, m_sv, m_tf;

  function automatic int clamp(int v);
    return (v > 2047) ? 2047 : (v < -2047) ? -2047 : v;
  endfunction
  function automatic int shape_m(int raw);
    return clamp(raw > 0 ? raw + DZ : raw < 0 ? raw - DZ : 0);
  endfunction
  function automatic int toward(int cur, int tgt);
    if (tgt - cur > 32)  return cur + 32;
    if (tgt - cur < -32) return cur - 32;
    return tgt;
  endfunction
  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  task automatic model_reset();
    m_st = M_OFF; m_shut = 0; m_lk = 0; m_s1l = 0; m_s1r = 0;
    m_vd = 0; m_l = 0; m_r = 0; m_sv = 0; m_tf = 0;
  endtask

  task automatic model_step();
    int nst, p, s;
    if (rst) begin model_reset(); return; end
    nst = m_st;
    if (m_st == M_OFF && pwr_up && !ovr) nst = M_RUN;
    if (m_st == M_RUN && (!pwr_up || ovr)) begin nst = M_STOP; m_shut = ovr; end
    if (m_st == M_LOCK && !pwr_up) begin nst = M_OFF; m_shut = 0; end
    if (m_st == M_STOP) begin
      m_shut = m_shut | ovr;
      if (m_l == 0 && m_r == 0) nst = m_shut ? M_LOCK : M_OFF;
    end
    if (m_vd) begin
      m_l = toward(m_l, m_st == M_RUN ? m_s1l : 0);
      m_r = toward(m_r, m_st == M_RUN ? m_s1r : 0);
    end
    m_sv = m_vd;
    m_tf = (iabs(m_l) > 1792) || (iabs(m_r) > 1792);
    p = pid; s = steer;
    if (vld) begin m_s1l = shape_m(p + s); m_s1r = shape_m(p - s); end
    m_vd = vld;
    m_st = nst;
    m_lk = (nst == M_LOCK);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("lft_spd", lft_spd, m_l);
    chk("rght_spd", rght_spd, m_r);
    chk("spd_vld", spd_vld, m_sv);
    chk("too_fast", too_fast, m_tf);
    chk("locked", locked, m_lk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; pwr_up = 1'b0; ovr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic signed [11:0] p;
    logic signed [11:0] s;
    int exp_l;
    int exp_r;
  } vec_t;
  vec_t tv[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [11:0] neg_max;
    int updates, seen, seen_hi, seen_lo;
    neg_max = 12'h800;
    tv[0] = '{12'sd2000, 12'sd300, 2047, 1700 + DZ};
    tv[1] = '{neg_max, 12'sd2047, -1 - DZ, -2047};
    tv[2] = '{12'sd5, 12'sd5, 10 + DZ, 0};
    tv[3] = '{12'sd0, 12'sd0, 0, 0};
    tv[4] = '{-12'sd100, 12'sd50, -50 - DZ, -150 - DZ};
    tv[5] = '{12'sd2047, 12'sd2047, 2047, 0};
    tv[6] = '{neg_max, neg_max, -2047, 0};

    // reset state
    rst = 1'b1; vld = 1'b0; pwr_up = 1'b0; ovr = 1'b0; pid = '0; steer = '0;
    model_reset();
    #1;
    compare_all();
    tick();
    rst = 1'b0;

    // ramp: one update every 8 cycles
    pwr_up = 1'b1;
    tick();
    for (int u = 1; u <= 20; u++) begin
      pid = 12'sd400; steer = 12'sd0; vld = 1'b1;
      tick();
      vld = 1'b0;
      tick();
      chk("ramp_spd_vld", spd_vld, 1);
      chk("ramp_lft", lft_spd, (32 * u < FINAL) ? 32 * u : FINAL);
      repeat (6) tick();
    end

    // over-current shutdown, ramp down and lock
    ovr = 1'b1;
    updates = 0;
    for (int k = 0; k < 40; k++) begin
      vld = 1'b1; tick(); vld = 1'b0; tick();
      updates++;
      if (lft_spd == 0 && rght_spd == 0) break;
      tick(); tick();
    end
    chk("shut_updates", updates, FIN_UPD);
    repeat (3) tick();
    chk("shut_locked", locked, 1);
    ovr = 1'b0;
    repeat (2) begin vld = 1'b1; tick(); vld = 1'b0; tick(); end
    chk("lock_hold_lft", lft_spd, 0);
    chk("lock_hold_locked", locked, 1);
    pwr_up = 1'b0;
    tick(); tick();
    chk("unlock", locked, 0);
    pwr_up = 1'b1;
    tick();
    vld = 1'b1; tick(); vld = 1'b0; tick();
    chk("rerun_lft", lft_spd, 32);

    // table of steady-state targets
    for (int i = 0; i < 7; i++) begin
      pid = tv[i].p; steer = tv[i].s; vld = 1'b1;
      repeat (140) tick();
      chk($sformatf("tbl%0d_lft", i), lft_spd, tv[i].exp_l);
      chk($sformatf("tbl%0d_rght", i), rght_spd, tv[i].exp_r);
    end

    // simultaneous power-down and shutdown must pass through LOCK
    pwr_up = 1'b0; ovr = 1'b1;
    tick();
    ovr = 1'b0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (locked) begin seen = 1; break; end
    end
    chk("race_lock", seen, 1);
    vld = 1'b0;

    // too_fast threshold crossing on a ramp up
    do_reset();
    pwr_up = 1'b1; pid = 12'sd2000; steer = 12'sd0; vld = 1'b1;
    seen_hi = 0; seen_lo = 0;
    repeat (80) begin
      tick();
      if (lft_spd == 12'sd1792) begin chk("tf_at_1792", too_fast, 0); seen_lo = 1; end
      if (lft_spd == 12'sd1824) begin chk("tf_at_1824", too_fast, 1); seen_hi = 1; end
    end
    chk("tf_seen", seen_hi + seen_lo, 2);
    vld = 1'b0;

    // async reset mid-ramp
    do_reset();
    pwr_up = 1'b1; pid = 12'sd400; steer = 12'sd0;
    tick();
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      vld = (k % 2 == 0);
      tick();
      if (lft_spd == 12'sd288) begin seen = 1; break; end
    end
    vld = 1'b0;
    chk("mid_ramp_288", seen, 1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_lft", lft_spd, 0);
    chk("arst_rght", rght_spd, 0);
    chk("arst_spd_vld", spd_vld, 0);
    chk("arst_too_fast", too_fast, 0);
    chk("arst_locked", locked, 0);
    tick();
    rst = 1'b0;

    // random traffic against the model
    pwr_up = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      vld = 1'($urandom_range(0, 1));
      pid = 12'($urandom);
      case ($urandom_range(0, 7))
        0: steer = pid;
        1: steer = -pid;
        2: steer = 12'($urandom_range(0, 8));
        default: steer = 12'($urandom);
      endcase
      if ($urandom_range(0, 99) < 3) pwr_up = ~pwr_up;
      ovr = ($urandom_range(0, 99) < 2);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spd_shaper.md
# spd_shaper

Motor-command conditioning stage between the balance PID and `mtr_drv`. It combines the PID output with a steering offset into signed left and right speed commands. Each command is saturated and given deadzone compensation, then slew-rate limited per control update. A power/fault state machine ramps both motors to zero on power-down or over-current shutdown, and latches off after a shutdown.

## Interface
- `MIN_DUTY`, 160: deadzone offset added to nonzero command magnitudes (11-bit unsigned).
- `SLEW`, 32: maximum output change per accepted update (11-bit unsigned, must be ≥1).
- `TOO_FAST_THR`, 1792: magnitude above which `too_fast` asserts.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `vld` in 1: one-cycle strobe; `PID_cntrl` and `steer` are valid this cycle.
- `PID_cntrl` in 12: signed balance command.
- `steer` in 12: signed steering offset.
- `pwr_up` in 1: rider/system enable, synchronous level.
- `OVR_I_shtdwn` in 1: shutdown level fed back from `mtr_drv`.
- `lft_spd` out 12: signed left speed to `mtr_drv`; reset 0.
- `rght_spd` out 12: signed right speed to `mtr_drv`; reset 0.
- `spd_vld` out 1: one-cycle pulse when outputs update; reset 0.
- `too_fast` out 1: registered, `|lft_spd|` or `|rght_spd|` > `TOO_FAST_THR`; reset 0.
- `locked` out 1: high in LOCK state; reset 0.

## Operation
- Stage 1, registered on `vld`:
  - `lft_raw = PID_cntrl + steer` and `rght_raw = PID_cntrl − steer`, computed in 13-bit signed.
  - Deadzone: raw > 0 adds `MIN_DUTY`; raw < 0 subtracts `MIN_DUTY`; raw == 0 stays 0.
  - Saturate to ±2047. The output is never −2048.
- Stage 2, registered one cycle after stage 1:
  - target = stage-1 value in RUN, 0 in STOP/OFF/LOCK.
  - delta = target − current, computed in 13-bit signed.
  - delta > `SLEW`: current += `SLEW`. delta < −`SLEW`: current −= `SLEW`. Otherwise current = target.
- States (package enum): OFF, RUN, STOP, LOCK. Evaluated every clock, independent of `vld`.
  - OFF → RUN: `pwr_up` & ~`OVR_I_shtdwn`.
  - RUN → STOP: ~`pwr_up` or `OVR_I_shtdwn`. A `shut_seen` flag is set if `OVR_I_shtdwn` caused the transition.
  - STOP: outputs ramp toward 0, one `SLEW` step per stage-2 update.
    - When both outputs reach 0: go to LOCK if `shut_seen`, else to OFF.
    - `OVR_I_shtdwn` asserting during STOP sets `shut_seen`.
  - LOCK: outputs held 0. LOCK → OFF only when `pwr_up` = 0; `shut_seen` clears on that transition.
- Simultaneous ~`pwr_up` and `OVR_I_shtdwn`: shutdown wins, so the path ends in LOCK.
- `spd_vld` pulses for every `vld` in every state, so `mtr_drv` sees a steady update cadence.
- Reset mid-operation: all pipeline registers, outputs and flags clear immediately; state = OFF.

## Timing
- Pipeline latency:
  - `vld` sampled at edge N; stage 1 updates at edge N.
  - Outputs, `too_fast` and `spd_vld` update at edge N+1, visible in cycle N+1.
- Back-to-back `vld` (every cycle) is supported at full throughput.
- State changes take effect on the stage-2 target at the next update after the transition edge.
- `locked` is registered with the state.

## Configuration
- `SPD_DEADZONE_COMP_EN` defined: deadzone offset applied as above.
- Undefined: `MIN_DUTY` is ignored and raw values pass straight to saturation. All other behaviour is identical.

## Structure
- Package `spd_pkg`:
  - state enum `spd_state_t`.
  - `SPD_MAX` = 12'sd2047 and `SPD_MIN` = −12'sd2047.
  - default values for `MIN_DUTY`, `SLEW`, `TOO_FAST_THR`.
- Sub-module `slew_lim`: one per side. Inputs: `clk`, `rst`, `step_en`, `target`. Output: registered `current`. Implements the stage-2 arithmetic.

## Test plan
- Ramp: pwr_up=1, PID=400, steer=0, vld every 8 cycles → `lft_spd` = `rght_spd` = 32, 64, … reaching 560 on update 18 and holding. `spd_vld` arrives 2 cycles after each `vld`.
- Saturation: in RUN at target, PID=2000, steer=300 → targets 2047 / 1860. PID=−2048, steer=2047 → `rght` target −2047 (never −2048).
- Zero and deadzone: PID=5, steer=5 → `rght` target 0 and `lft` target 170. Repeat with `SPD_DEADZONE_COMP_EN` undefined → `lft` target 10.
- Shutdown: RUN at 560/560, assert `OVR_I_shtdwn` → ramp down 32 per update to 0 in 18 updates, then LOCK with `locked`=1. Further vld keeps outputs 0. pwr_up 0 → OFF; pwr_up 1 with shutdown clear → RUN.
- Power-down race: ~`pwr_up` and `OVR_I_shtdwn` asserted on the same edge → ends in LOCK, not OFF.
- Reset mid-ramp at `lft_spd`=288 → outputs, `too_fast`, `spd_vld`, `locked` = 0 asynchronously; state OFF. `too_fast` asserts at 1824 and deasserts at 1792.
